// File: rtl/dmem_responder_pkg.sv
// Shared constants for the data-port responder: MMIO register offsets, STATUS bit positions
// and the UART transmitter state encoding.
package dmem_responder_pkg;

    // Word offsets inside the 16-byte MMIO window (d_addr[3:2])
    localparam logic [1:0] OffTxData  = 2'd0;
    localparam logic [1:0] OffStatus  = 2'd1;
    localparam logic [1:0] OffMtimeLo = 2'd2;
    localparam logic [1:0] OffMtimeHi = 2'd3;

    localparam int unsigned StatBusy  = 0;
    localparam int unsigned StatFull  = 1;
    localparam int unsigned StatEmpty = 2;
    localparam int unsigned StatOvf   = 3;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_state_t;

    function automatic logic [31:0] pack_status(input logic [7:0] count, input logic ovf,
                                                input logic empty, input logic full,
                                                input logic busy);
        logic [31:0] s;
        s            = '0;
        s[15:8]      = count;
        s[StatOvf]   = ovf;
        s[StatEmpty] = empty;
        s[StatFull]  = full;
        s[StatBusy]  = busy;
        return s;
    endfunction

endpackage

// File: rtl/dmem_responder_uart_tx.sv
// 8N1 serial transmitter: pulls one byte from the TX FIFO when idle and shifts it out LSB first.
module dmem_responder_uart_tx
    import dmem_responder_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ready,
    input  logic [7:0] data,
    output logic       pop,
    output logic       txd,
    output logic       busy
);

    localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
    localparam logic [BaudW-1:0] BaudReload = BaudW'(CLKS_PER_BIT - 1);

    uart_state_t      state_q;
    logic [BaudW-1:0] baud_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             txd_q;
    logic             busy_q;

    assign pop  = (state_q == StIdle) && ready;
    assign txd  = txd_q;
    assign busy = busy_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ready) begin
                        shift_q <= data;
                        baud_q  <= BaudReload;
                        txd_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (baud_q == '0) begin
                        baud_q  <= BaudReload;
                        bit_q   <= '0;
                        txd_q   <= shift_q[0];
                        state_q <= StData;
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                StData: begin
                    if (baud_q == '0) begin
                        baud_q <= BaudReload;
                        if (bit_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= StStop;
                        end else begin
                            // Shift register keeps the next bit at [1] while [0] is on the line
                            bit_q   <= bit_q + 1'b1;
                            shift_q <= shift_q >> 1;
                            txd_q   <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                StStop: begin
                    if (baud_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-port responder: word RAM at 0, MMIO window with UART TX FIFO, status and a 64-bit timer.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned RAM_WORDS    = 4096,
    parameter logic [31:0] MMIO_BASE    = 32'h8000_0000,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_we,
    input  logic [31:0] d_wr_data,
    output logic [31:0] d_rd_data,
    output logic        uart_txd,
    output logic        tx_busy
);

    localparam int unsigned AddrW = $clog2(RAM_WORDS);
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;

    // Address decode
    logic             ram_sel;
    logic             mmio_sel;
    logic [AddrW-1:0] ram_idx;
    logic [1:0]       mmio_off;
    logic             unused_addr_lsb;

    assign ram_sel         = (d_addr[31:AddrW+2] == '0);
    assign mmio_sel        = (d_addr[31:4] == MMIO_BASE[31:4]);
    assign ram_idx         = d_addr[AddrW+1:2];
    assign mmio_off        = d_addr[3:2];
    assign unused_addr_lsb = ^d_addr[1:0];

    // Word RAM, contents deliberately not reset
    logic [31:0] mem [RAM_WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (ram_sel && d_we[b]) begin
                mem[ram_idx][8*b +: 8] <= d_wr_data[8*b +: 8];
            end
        end
    end

    // TX FIFO
    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            ovf_q;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push_req;
    logic            push_ok;
    logic            pop;
    logic            ovf_clr;
    logic [7:0]      fifo_head;

    assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push_req   = mmio_sel && (mmio_off == OffTxData) && d_we[0];
    // A pop at the same edge frees a slot, so a push into a full FIFO still lands
    assign push_ok    = push_req && (!fifo_full || pop);
    assign ovf_clr    = mmio_sel && (mmio_off == OffStatus) && d_we[0] && d_wr_data[StatOvf];
    assign fifo_head  = fifo_mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= d_wr_data[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_ok && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (!push_ok && pop) begin
                count_q <= count_q - 1'b1;
            end
            if (push_req && !push_ok) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    dmem_responder_uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clk  (clk),
        .rst  (rst),
        .ready(!fifo_empty),
        .data (fifo_head),
        .pop  (pop),
        .txd  (uart_txd),
        .busy (tx_busy)
    );

    // Timer, high-word snapshot and registered read data
    logic [63:0] timer_q;
    logic [31:0] hi_shadow_q;
    logic [31:0] rd_data_q;
    logic [31:0] rd_data_d;
    logic        hi_cap;

    assign hi_cap    = mmio_sel && (mmio_off == OffMtimeLo) && (d_we == '0);
    assign d_rd_data = rd_data_q;

    always_comb begin
        rd_data_d = '0;
        if (ram_sel) begin
            rd_data_d = mem[ram_idx];
        end else if (mmio_sel) begin
            unique case (mmio_off)
                OffTxData:  rd_data_d = '0;
                OffStatus:  rd_data_d = pack_status(8'(count_q), ovf_q, fifo_empty, fifo_full,
                                                    tx_busy);
                OffMtimeLo: rd_data_d = timer_q[31:0];
                OffMtimeHi: rd_data_d = hi_shadow_q;
                default:    rd_data_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_q     <= '0;
            hi_shadow_q <= '0;
            rd_data_q   <= '0;
        end else begin
            timer_q   <= timer_q + 64'd1;
            rd_data_q <= rd_data_d;
            if (hi_cap) begin
                hi_shadow_q <= timer_q[63:32];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a cycle-timeline reference model.
module tb_dmem_responder;

    localparam int unsigned RamWords    = 4096;
    localparam int unsigned FifoDepth   = 4;
    localparam int unsigned ClksPerBit  = 4;
    localparam logic [31:0] MmioBase    = 32'h8000_0000;
    localparam int          FrameLen    = 10 * ClksPerBit;
    localparam int          FramePeriod = FrameLen + 1;

    logic        clk;
    logic        rst;
    logic [31:0] d_addr;
    logic [3:0]  d_we;
    logic [31:0] d_wr_data;
    logic [31:0] d_rd_data;
    logic        uart_txd;
    logic        tx_busy;

    dmem_responder #(
        .RAM_WORDS   (RamWords),
        .MMIO_BASE   (MmioBase),
        .FIFO_DEPTH  (FifoDepth),
        .CLKS_PER_BIT(ClksPerBit)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .d_addr   (d_addr),
        .d_we     (d_we),
        .d_wr_data(d_wr_data),
        .d_rd_data(d_rd_data),
        .uart_txd (uart_txd),
        .tx_busy  (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [31:0] mem_m [int];
    logic [7:0]  fifo_m [$];
    logic        ovf_m = 1'b0;
    logic [63:0] timer_m = '0;
    logic [31:0] shadow_m = '0;
    bit          timer_ok = 1'b1;
    int          edge_n = 0;
    int          last_pop = -1000;
    logic [7:0]  cur_byte = '0;
    int          starts [$];
    logic        prev_busy = 1'b0;

    function automatic bit is_ram(input logic [31:0] a);
        return a < 32'(RamWords * 4);
    endfunction

    function automatic bit is_mmio(input logic [31:0] a);
        return (a >= MmioBase) && (a < MmioBase + 32'd16);
    endfunction

    // Frame popped at edge P drives the line for edges P .. P+FrameLen-1
    function automatic bit busy_at(input int e);
        int k;
        k = e - last_pop;
        return (k >= 0) && (k < FrameLen);
    endfunction

    function automatic bit txd_at(input int e);
        int slot;
        if (!busy_at(e)) return 1'b1;
        slot = (e - last_pop) / ClksPerBit;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return cur_byte[slot-1];
        return 1'b1;
    endfunction

    function automatic logic [31:0] status_m();
        logic [31:0] s;
        s        = '0;
        s[15:8]  = 8'(fifo_m.size());
        s[3]     = ovf_m;
        s[2]     = (fifo_m.size() == 0);
        s[1]     = (fifo_m.size() == FifoDepth);
        s[0]     = busy_at(edge_n - 1);
        return s;
    endfunction

    // One clock edge with the current inputs; scoreboard every output afterwards
    task automatic step();
        logic [31:0] a, wd, exp_rd;
        logic [3:0]  we;
        bit          chk, push, clr, cap, pop;
        int          w;
        a = d_addr; we = d_we; wd = d_wr_data;
        chk = 1'b1; exp_rd = '0;
        if (is_ram(a)) begin
            w = int'(a >> 2);
            if (mem_m.exists(w)) exp_rd = mem_m[w];
            else chk = 1'b0;
        end else if (is_mmio(a)) begin
            case (a[3:2])
                2'd1: exp_rd = status_m();
                2'd2: begin exp_rd = timer_m[31:0]; chk = timer_ok; end
                2'd3: begin exp_rd = shadow_m; chk = timer_ok; end
                default: exp_rd = '0;
            endcase
        end
        push = is_mmio(a) && (a[3:2] == 2'd0) && we[0];
        clr  = is_mmio(a) && (a[3:2] == 2'd1) && we[0] && wd[3];
        cap  = is_mmio(a) && (a[3:2] == 2'd2) && (we == 4'd0);
        pop  = (fifo_m.size() > 0) && (edge_n >= last_pop + FramePeriod);
        @(posedge clk);
        #1;
        if (pop) begin
            cur_byte = fifo_m.pop_front();
            last_pop = edge_n;
        end
        if (push) begin
            if (fifo_m.size() < FifoDepth) fifo_m.push_back(wd[7:0]);
            else ovf_m = 1'b1;
        end
        if (clr) ovf_m = 1'b0;
        if (cap) shadow_m = timer_m[63:32];
        timer_m = timer_m + 64'd1;
        if (is_ram(a) && we != 4'd0) begin
            w = int'(a >> 2);
            if (mem_m.exists(w)) begin
                for (int b = 0; b < 4; b++)
                    if (we[b]) mem_m[w][8*b +: 8] = wd[8*b +: 8];
            end else if (we == 4'hF) begin
                mem_m[w] = wd;
            end
        end
        if (chk) check("rd", d_rd_data, exp_rd);
        check("busy", tx_busy, busy_at(edge_n));
        check("txd", uart_txd, txd_at(edge_n));
        if (tx_busy === 1'b1 && !prev_busy) starts.push_back(edge_n);
        prev_busy = tx_busy;
        edge_n++;
    endtask

    task automatic drive(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
        d_addr = a; d_we = we; d_wr_data = wd;
        step();
    endtask

    task automatic wait_idle();
        int n;
        d_addr = '0; d_we = '0; d_wr_data = '0;
        n = 0;
        while ((fifo_m.size() != 0 || edge_n < last_pop + FramePeriod) && n < 1000) begin
            step();
            n++;
        end
        if (n >= 1000) check("idle_wait", 1'b0, 1'b1);
    endtask

    task automatic model_reset();
        fifo_m.delete();
        ovf_m     = 1'b0;
        timer_m   = '0;
        shadow_m  = '0;
        timer_ok  = 1'b1;
        last_pop  = -1000;
        prev_busy = 1'b0;
    endtask

    // Called 1 time unit after a rising edge; asserts reset between edges
    task automatic reset_mid();
        #2 rst = 1'b0;
        #1;
        check("rst_txd", uart_txd, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_rd", d_rd_data, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          pool [8];
        int          r;
        logic [63:0] gv_txd, gv_busy, ev_txd, ev_busy;
        logic [7:0]  a5;
        int          slot;

        rst = 1'b1; d_addr = '0; d_we = '0; d_wr_data = '0;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rd", d_rd_data, 32'd0);
        check("reset_txd", uart_txd, 1'b1);
        check("reset_busy", tx_busy, 1'b0);
        rst = 1'b1;
        model_reset();

        drive(MmioBase + 32'h4, 4'd0, 32'd0);
        check("status_reset", d_rd_data, 32'h0000_0004);

        // Byte-lane merge and read-during-write
        drive(32'h10, 4'hF, 32'hDEAD_BEEF);
        drive(32'h10, 4'b0010, 32'h0000_5500);
        drive(32'h10, 4'd0, 32'd0);
        check("ram_lane", d_rd_data, 32'hDEAD_55EF);
        drive(32'h10, 4'hF, 32'h1234_5678);
        check("ram_rdw_old", d_rd_data, 32'hDEAD_55EF);
        drive(32'h10, 4'd0, 32'd0);
        check("ram_rdw_new", d_rd_data, 32'h1234_5678);

        // Unmapped space
        drive(32'h0, 4'hF, 32'hCAFE_F00D);
        drive(32'h4000_0000, 4'hF, $urandom);
        drive(32'h4000_0000, 4'd0, 32'd0);
        check("unmapped_rd", d_rd_data, 32'd0);
        drive(32'h0, 4'd0, 32'd0);
        check("unmapped_wr", d_rd_data, 32'hCAFE_F00D);
        drive(MmioBase + 32'h10, 4'd0, 32'd0);

        // Random mixed traffic
        foreach (pool[i]) begin
            pool[i] = int'($urandom_range(0, RamWords - 1));
            drive(32'(pool[i] * 4), 4'hF, $urandom);
        end
        for (int i = 0; i < 250; i++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 5) begin
                slot = int'($urandom_range(0, 2));
                drive(32'(pool[$urandom_range(0, 7)] * 4),
                      (slot == 0) ? 4'd0 : (slot == 1) ? 4'hF : 4'($urandom), $urandom);
            end else if (r == 6) begin
                drive(MmioBase + 32'($urandom_range(0, 3) * 4), 4'($urandom), $urandom);
            end else if (r == 7) begin
                drive({2'b01, 30'($urandom)}, 4'($urandom), $urandom);
            end else begin
                drive(MmioBase + ((r == 8) ? 32'h8 : 32'hC), 4'd0, 32'd0);
            end
        end

        // Single frame 0xA5, exact waveform
        wait_idle();
        a5 = 8'hA5;
        drive(MmioBase, 4'b0001, 32'h0000_00A5);
        gv_txd = '0; gv_busy = '0; ev_txd = '0; ev_busy = '0;
        gv_txd[0] = uart_txd; gv_busy[0] = tx_busy; ev_txd[0] = 1'b1;
        d_addr = '0; d_we = '0;
        for (int i = 1; i < 45; i++) begin
            step();
            gv_txd[i] = uart_txd; gv_busy[i] = tx_busy;
            ev_busy[i] = (i <= 40);
            slot = (i - 1) / 4;
            if (i > 40) ev_txd[i] = 1'b1;
            else if (slot == 0) ev_txd[i] = 1'b0;
            else if (slot <= 8) ev_txd[i] = a5[slot-1];
            else ev_txd[i] = 1'b1;
        end
        check("a5_txd", gv_txd, ev_txd);
        check("a5_busy", gv_busy, ev_busy);

        // FIFO fill, overflow, clear, drain
        wait_idle();
        drive(MmioBase + 32'h4, 4'b0001, 32'h8);
        starts.delete();
        for (int i = 0; i < 6; i++) drive(MmioBase, 4'b0001, 32'(8'h31 + i));
        drive(MmioBase + 32'h4, 4'd0, 32'd0);
        check("fifo_status_full", d_rd_data, 32'h0000_040B);
        drive(MmioBase + 32'h4, 4'b0001, 32'h8);
        drive(MmioBase + 32'h4, 4'd0, 32'd0);
        check("fifo_status_clr", d_rd_data, 32'h0000_0403);
        d_addr = '0; d_we = '0;
        repeat (5 * FramePeriod + 10) step();
        check("fifo_frames", 64'(starts.size()), 64'd5);
        for (int i = 1; i < starts.size(); i++)
            check("fifo_gap", 64'(starts[i] - starts[i-1]), 64'd41);

        // Random UART traffic
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 3) drive(MmioBase, 4'b0001, $urandom);
            else if (r == 4) drive(MmioBase + 32'h4, 4'b0001, 32'h8);
            else if (r == 5) drive(MmioBase + 32'h4, 4'd0, 32'd0);
            else drive(32'h0, 4'd0, 32'd0);
        end
        wait_idle();

        // Timer carry into the high word via the snapshot
        timer_ok = 1'b0;
        force dut.timer_q = 64'h0000_0000_FFFF_FFFF;
        drive(MmioBase + 32'h8, 4'd0, 32'd0);
        check("lo_pre_wrap", d_rd_data, 32'hFFFF_FFFF);
        drive(MmioBase + 32'hC, 4'd0, 32'd0);
        check("hi_snapshot", d_rd_data, 32'd0);
        release dut.timer_q;
        drive(32'h0, 4'd0, 32'd0);
        drive(MmioBase + 32'h8, 4'd0, 32'd0);
        check("lo_post_wrap", 64'(d_rd_data < 32'd16), 64'd1);
        drive(MmioBase + 32'hC, 4'd0, 32'd0);
        check("hi_carry", d_rd_data, 32'd1);

        // Asynchronous reset in the middle of a data bit
        drive(MmioBase, 4'b0001, 32'h00);
        drive(MmioBase, 4'b0001, 32'h77);
        d_addr = '0; d_we = '0;
        repeat (9) step();
        check("pre_rst_txd", uart_txd, 1'b0);
        reset_mid();
        drive(MmioBase + 32'h4, 4'd0, 32'd0);
        check("status_after_rst", d_rd_data, 32'h0000_0004);
        d_addr = '0;
        repeat (50) step();
        drive(MmioBase + 32'h8, 4'd0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
